// File: rtl/keypad_pkg.sv
// keypad_pkg: shared scanner state encoding, default timing and key encoding helpers
package keypad_pkg;
  localparam int SCAN_DIV_DEF = 5;
  localparam int DEBOUNCE_CNT_DEF = 8;
  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;
  function automatic logic [3:0] key_encode(input logic [3:0] row_n, input logic [1:0] col_idx);
    logic [1:0] r;
    r = !row_n[0] ? 2'd0 : !row_n[1] ? 2'd1 : !row_n[2] ? 2'd2 : 2'd3;
    return {r, col_idx};
  endfunction
  function automatic logic single_low(input logic [3:0] row_n);
    return $countones(~row_n) == 1;
  endfunction
endpackage

// File: rtl/scan_tick.sv
// scan_tick: free-running divider producing a one-cycle tick every DIV clocks
module scan_tick #(
  parameter int DIV = 5
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  localparam int W = DIV > 1 ? $clog2(DIV) : 1;
  logic [W-1:0] div;
  assign tick = div == W'(DIV - 1);
  always_ff @(posedge clk or negedge rst)
    if (!rst) div <= '0;
    else div <= tick ? '0 : div + 1'b1;
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix scanner with tick-based debounce and a one-deep key mailbox
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = SCAN_DIV_DEF,
  parameter int DEBOUNCE_CNT = DEBOUNCE_CNT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  input  logic       key_ack,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_pressed,
  output logic       overrun
);
  localparam int CW = $clog2(DEBOUNCE_CNT + 1);
  logic [3:0] r1, rs, cap_row, cap_row_n;
  logic [1:0] col_idx, col_idx_n;
  logic [CW-1:0] cnt, cnt_n, cnt_inc;
  logic tick, idle_rows, match, done, emit;
  state_t state, state_n;

  scan_tick #(.DIV(SCAN_DIV)) u_tick (.clk(clk), .rst(rst), .tick(tick));

  always_ff @(posedge clk or negedge rst)
    if (!rst) {r1, rs} <= 8'hFF;
    else {r1, rs} <= {row, r1};

  assign idle_rows = rs == 4'hF;
  assign match = rs == cap_row;
  assign cnt_inc = cnt + 1'b1;
  assign done = int'(cnt_inc) >= DEBOUNCE_CNT - 1;
  assign col = ~(4'b0001 << col_idx);
  assign key_pressed = state == HELD || state == RELEASE;

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= SCAN;
      col_idx <= '0;
      cap_row <= 4'hF;
      cnt <= '0;
    end else begin
      state <= state_n;
      col_idx <= col_idx_n;
      cap_row <= cap_row_n;
      cnt <= cnt_n;
    end

  // the column stays put outside SCAN, so col_idx is the captured column
  always_comb begin
    state_n = state;
    col_idx_n = col_idx;
    cap_row_n = cap_row;
    cnt_n = cnt;
    emit = 1'b0;
    if (tick)
      case (state)
        SCAN:
          if (!idle_rows) begin
            state_n = DEBOUNCE;
            cap_row_n = rs;
            cnt_n = '0;
          end else col_idx_n = col_idx + 1'b1;
        DEBOUNCE:
          if (!match) begin
            state_n = SCAN;
            col_idx_n = col_idx + 1'b1;
          end else if (done) begin
            state_n = HELD;
            emit = single_low(cap_row);
          end else cnt_n = cnt_inc;
        HELD:
          if (idle_rows) begin
            state_n = RELEASE;
            cnt_n = '0;
          end
        RELEASE:
          if (!idle_rows) state_n = HELD;
          else if (done) begin
            state_n = SCAN;
            col_idx_n = col_idx + 1'b1;
          end else cnt_n = cnt_inc;
        default: state_n = SCAN;
      endcase
  end

  // an emit racing an ack replaces the pending code without flagging a loss
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      key_code <= '0;
      key_valid <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (emit && (!key_valid || key_ack)) key_code <= key_encode(cap_row, col_idx);
      key_valid <= emit || (key_valid && !key_ack);
      overrun <= (emit && key_valid && !key_ack) ? 1'b1 : key_ack ? 1'b0 : overrun;
    end
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed vector table plus hand sequences against a 4x4 key matrix model
module tb_keypad_scanner;
  logic clk = 1'b0, rst = 1'b0, key_ack = 1'b0, glitch = 1'b0;
  logic [3:0] row, col, key_code;
  logic key_valid, key_pressed, overrun;
  logic [15:0] keys = '0;
  logic valid_q = 1'b0;
  int checks = 0, errors = 0, cyc = 0, rises = 0;

  typedef struct {
    logic [15:0] keys;
    int          hold;
    logic        ack;
    logic        valid;
    logic [3:0]  code;
    logic        ovr;
    logic        pressed;
  } vec_t;
  vec_t tbl[11];

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CNT(3)) dut (
    .clk(clk), .rst(rst), .row(row), .col(col), .key_ack(key_ack),
    .key_code(key_code), .key_valid(key_valid), .key_pressed(key_pressed), .overrun(overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    valid_q <= key_valid;
    if (key_valid && !valid_q) rises <= rises + 1;
  end

  // key r*4+c pulls row r low while column c is driven low
  always_comb begin
    for (int r = 0; r < 4; r++) row[r] = ~|(keys[r*4 +: 4] & ~col);
    if (glitch) row[0] = 1'b0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_ab(input int ack_at, output int e);
    int base;
    rst = 1'b0; keys = '0; key_ack = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    base = cyc;
    keys = 16'h0001;
    repeat (40) @(negedge clk);
    keys = '0;
    repeat (40) @(negedge clk);
    keys = 16'h0040;
    e = -1;
    for (int i = 0; i < 60; i++) begin
      key_ack = ack_at > 0 && (cyc - base) == ack_at - 1;
      @(negedge clk);
      if (e < 0 && overrun) e = cyc - base;
    end
    key_ack = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int e1, e2, n;
    logic [3:0] prev, exp_col;
    tbl[0]  = '{16'h0000, 20, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0};
    tbl[1]  = '{16'h0200, 40, 1'b0, 1'b1, 4'h9, 1'b0, 1'b1};
    tbl[2]  = '{16'h0000, 40, 1'b1, 1'b1, 4'h9, 1'b0, 1'b0};
    tbl[3]  = '{16'h0000,  4, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0};
    tbl[4]  = '{16'h0008, 40, 1'b0, 1'b1, 4'h3, 1'b0, 1'b1};
    tbl[5]  = '{16'h0000, 40, 1'b0, 1'b1, 4'h3, 1'b0, 1'b0};
    tbl[6]  = '{16'h1000, 40, 1'b0, 1'b1, 4'h3, 1'b1, 1'b1};
    tbl[7]  = '{16'h0000, 40, 1'b1, 1'b1, 4'h3, 1'b1, 1'b0};
    tbl[8]  = '{16'h0000,  4, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0};
    tbl[9]  = '{16'h0044, 40, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1};
    tbl[10] = '{16'h0000, 40, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0};

    @(negedge clk);
    chk("rst_col", 32'(col), 32'(4'b1110));
    chk("rst_valid", 32'(key_valid), 32'd0);
    chk("rst_code", 32'(key_code), 32'd0);
    chk("rst_pressed", 32'(key_pressed), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    rst = 1'b1;

    exp_col = 4'b1110;
    for (int i = 0; i < 4; i++) begin
      prev = col;
      n = 0;
      while (col == prev && n < 10) begin @(negedge clk); n++; end
      exp_col = {exp_col[2:0], exp_col[3]};
      chk($sformatf("idle_col%0d", i), 32'(col), 32'(exp_col));
      chk($sformatf("idle_period%0d", i), n, 4);
    end
    chk("idle_valid", 32'(key_valid), 32'd0);

    for (int i = 0; i < 11; i++) begin
      keys = tbl[i].keys;
      repeat (tbl[i].hold) @(negedge clk);
      chk($sformatf("vec%0d_valid", i), 32'(key_valid), 32'(tbl[i].valid));
      if (tbl[i].valid) chk($sformatf("vec%0d_code", i), 32'(key_code), 32'(tbl[i].code));
      chk($sformatf("vec%0d_overrun", i), 32'(overrun), 32'(tbl[i].ovr));
      chk($sformatf("vec%0d_pressed", i), 32'(key_pressed), 32'(tbl[i].pressed));
      if (tbl[i].ack) begin
        key_ack = 1'b1;
        @(negedge clk);
        key_ack = 1'b0;
      end
    end
    chk("valid_rises", rises, 2);

    glitch = 1'b1;
    repeat (6) @(negedge clk);
    glitch = 1'b0;
    repeat (30) @(negedge clk);
    chk("glitch_valid", 32'(key_valid), 32'd0);
    chk("glitch_pressed", 32'(key_pressed), 32'd0);
    prev = col;
    n = 0;
    while (col == prev && n < 10) begin @(negedge clk); n++; end
    chk("glitch_rescan", 32'(col != prev), 32'd1);

    run_ab(0, e1);
    chk("ab_emit_seen", 32'(e1 > 0), 32'd1);
    chk("ab_valid", 32'(key_valid), 32'd1);
    chk("ab_code_kept", 32'(key_code), 32'h0);
    chk("ab_overrun", 32'(overrun), 32'd1);
    run_ab(e1, e2);
    chk("race_valid", 32'(key_valid), 32'd1);
    chk("race_code", 32'(key_code), 32'h6);
    chk("race_overrun", 32'(overrun), 32'd0);

    keys = '0;
    repeat (40) @(negedge clk);
    keys = 16'h0200;
    n = 0;
    while (col != 4'b1101 && n < 20) begin @(negedge clk); n++; end
    chk("dbn_col1", 32'(col), 32'(4'b1101));
    repeat (6) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_valid", 32'(key_valid), 32'd0);
    chk("arst_code", 32'(key_code), 32'd0);
    chk("arst_overrun", 32'(overrun), 32'd0);
    chk("arst_pressed", 32'(key_pressed), 32'd0);
    chk("arst_col", 32'(col), 32'(4'b1110));
    @(negedge clk);
    rst = 1'b1;
    repeat (12) @(negedge clk);
    chk("arst_no_early_emit", 32'(key_valid), 32'd0);
    n = 0;
    while (!key_valid && n < 40) begin @(negedge clk); n++; end
    chk("arst_late_valid", 32'(key_valid), 32'd1);
    chk("arst_late_code", 32'(key_code), 32'h9);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
